branch_feedback_queue: RTL and testbench

- In-order FIFO between fetch/decode and the bimodal predictor's feedback port.
- Records (pc, prediction) for every predicted branch at fetch.
- Pops the head when EX resolves the oldest branch, then drives registered feedback (valid, pc, prediction, outcome, mispredict) one cycle later.
- Flush empties the queue on pipeline redirect.

---
 rtl/mips_core_pkg.sv | 13 +
 rtl/branch_feedback_queue_if.sv | 46 ++++
 rtl/branch_feedback_queue.sv | 103 ++++++++++
 tb/tb_branch_feedback_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding and the default PC width macro.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

endpackage

// File: rtl/branch_feedback_queue_if.sv
// Bundle between fetch/EX (master) and the branch feedback queue (slave).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface branch_feedback_queue_if #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
);
  import mips_core_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  i_push_valid;
  logic [ADDR_WIDTH-1:0] i_push_pc;
  BranchOutcome          i_push_prediction;
  logic                  o_push_ready;
  logic                  i_resolve_valid;
  logic [ADDR_WIDTH-1:0] i_resolve_pc;
  BranchOutcome          i_resolve_outcome;
  logic                  i_flush;
  logic                  o_fb_valid;
  logic [ADDR_WIDTH-1:0] o_fb_pc;
  BranchOutcome          o_fb_prediction;
  BranchOutcome          o_fb_outcome;
  logic                  o_fb_mispredict;
  logic [CNT_W-1:0]      o_count;
  logic                  o_empty;
  logic                  o_underflow;
  logic                  o_pc_mismatch;

  modport master (
    output i_push_valid, i_push_pc, i_push_prediction,
    output i_resolve_valid, i_resolve_pc, i_resolve_outcome, i_flush,
    input  o_push_ready, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
    input  o_fb_mispredict, o_count, o_empty, o_underflow, o_pc_mismatch
  );

  modport slave (
    input  i_push_valid, i_push_pc, i_push_prediction,
    input  i_resolve_valid, i_resolve_pc, i_resolve_outcome, i_flush,
    output o_push_ready, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
    output o_fb_mispredict, o_count, o_empty, o_underflow, o_pc_mismatch
  );

endinterface

// File: rtl/branch_feedback_queue.sv
// In-order queue of (pc, prediction) for predicted branches; pops on EX resolve
// and drives registered predictor feedback one cycle later.
// Optional macro BFQ_PC_CHECK_EN: cross-check resolve PC against the head entry
// and suppress training on a mismatch.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_feedback_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  branch_feedback_queue_if.slave  bfq
);
  import mips_core_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    BranchOutcome          prediction;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             res_ok;
  logic             pc_bad;

  assign head         = mem[rd_ptr];
  assign bfq.o_count  = count;
  assign bfq.o_empty  = (count == '0);
  // Ready looks only at the registered count, never at a same-cycle pop.
  assign bfq.o_push_ready = (count != CNT_W'(DEPTH));

  assign push_ok     = bfq.i_push_valid && bfq.o_push_ready && !bfq.i_flush;
  assign res_ok      = bfq.i_resolve_valid && (count != '0);
  assign rd_ptr_next = rd_ptr + PTR_W'(res_ok);

`ifdef BFQ_PC_CHECK_EN
  assign pc_bad = res_ok && (bfq.i_resolve_pc != head.pc);
`else
  logic unused_resolve_pc;
  assign pc_bad            = 1'b0;
  assign unused_resolve_pc = ^bfq.i_resolve_pc;
`endif

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{pc: bfq.i_push_pc, prediction: bfq.i_push_prediction};
    end
  end

  // Pointers and occupancy; flush discards everything behind the popped head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      if (bfq.i_flush) begin
        wr_ptr <= rd_ptr_next;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(push_ok);
        count  <= count + CNT_W'(push_ok) - CNT_W'(res_ok);
      end
    end
  end

  // Registered feedback; fields hold their last values between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bfq.o_fb_valid      <= 1'b0;
      bfq.o_fb_pc         <= '0;
      bfq.o_fb_prediction <= NOT_TAKEN;
      bfq.o_fb_outcome    <= NOT_TAKEN;
      bfq.o_fb_mispredict <= 1'b0;
      bfq.o_underflow     <= 1'b0;
      bfq.o_pc_mismatch   <= 1'b0;
    end else begin
      bfq.o_fb_valid    <= res_ok && !pc_bad;
      bfq.o_underflow   <= bfq.i_resolve_valid && (count == '0);
      bfq.o_pc_mismatch <= pc_bad;
      if (res_ok && !pc_bad) begin
        bfq.o_fb_pc         <= head.pc;
        bfq.o_fb_prediction <= head.prediction;
        bfq.o_fb_outcome    <= bfq.i_resolve_outcome;
        bfq.o_fb_mispredict <= (head.prediction != bfq.i_resolve_outcome);
      end
    end
  end

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Directed bench for branch_feedback_queue (DEPTH = 8, 32-bit PCs).
`timescale 1ns/1ps

module tb_branch_feedback_queue;
  import mips_core_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [AW:0] exp_q[$];

  always #5 clk = ~clk;

  branch_feedback_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bfq ();

  branch_feedback_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bfq   (bfq)
  );

  function automatic logic [35:0] fb_snap();
    return {bfq.o_fb_valid, bfq.o_fb_pc, bfq.o_fb_prediction, bfq.o_fb_outcome,
            bfq.o_fb_mispredict};
  endfunction

  task automatic idle_inputs();
    bfq.i_push_valid      = 1'b0;
    bfq.i_push_pc         = '0;
    bfq.i_push_prediction = NOT_TAKEN;
    bfq.i_resolve_valid   = 1'b0;
    bfq.i_resolve_pc      = '0;
    bfq.i_resolve_outcome = NOT_TAKEN;
    bfq.i_flush           = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle(input logic pv, input logic [AW-1:0] ppc, input BranchOutcome pp,
                       input logic rv, input logic [AW-1:0] rpc, input BranchOutcome ro,
                       input logic fl);
    bfq.i_push_valid      = pv;
    bfq.i_push_pc         = ppc;
    bfq.i_push_prediction = pp;
    bfq.i_resolve_valid   = rv;
    bfq.i_resolve_pc      = rpc;
    bfq.i_resolve_outcome = ro;
    bfq.i_flush           = fl;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [35:0] got;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({bfq.o_empty, bfq.o_push_ready, bfq.o_count} !== {1'b1, 1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL reset_status: got empty=%b ready=%b count=%0d exp 1 1 0",
               bfq.o_empty, bfq.o_push_ready, bfq.o_count);
    end
    got = fb_snap();
    n_cmp++;
    if ({got, bfq.o_underflow, bfq.o_pc_mismatch} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_fb: got fb=%h uf=%b pcm=%b exp all 0",
               got, bfq.o_underflow, bfq.o_pc_mismatch);
    end
  endtask

  task automatic test_basic();
    logic [35:0] got, exp;
    cycle(1'b1, 32'h100, TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    cycle(1'b1, 32'h104, NOT_TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    n_cmp++;
    if (bfq.o_count !== 4'd2) begin
      n_err++;
      $display("FAIL basic_count: got %0d exp 2", bfq.o_count);
    end
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h100, NOT_TAKEN, 1'b0);
    got = fb_snap(); exp = {1'b1, 32'h100, TAKEN, NOT_TAKEN, 1'b1};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL basic_fb0: got %h exp %h", got, exp);
    end
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h104, TAKEN, 1'b0);
    got = fb_snap(); exp = {1'b1, 32'h104, NOT_TAKEN, TAKEN, 1'b1};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL basic_fb1: got %h exp %h", got, exp);
    end
    step();
    got = fb_snap(); exp = {1'b0, 32'h104, NOT_TAKEN, TAKEN, 1'b1};
    n_cmp++;
    if ({got, bfq.o_empty} !== {exp, 1'b1}) begin
      n_err++;
      $display("FAIL basic_hold: got %h empty=%b exp %h empty=1", got, bfq.o_empty, exp);
    end
    cycle(1'b1, 32'h108, TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h108, TAKEN, 1'b0);
    got = fb_snap(); exp = {1'b1, 32'h108, TAKEN, TAKEN, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL basic_correct: got %h exp %h", got, exp);
    end
  endtask

  task automatic test_full_wrap();
    logic [35:0] got, exp;
    logic [AW:0] hd;
    logic [AW-1:0] npc;
    BranchOutcome np, ro;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      npc = 32'h1000 + 32'(4 * i);
      np  = BranchOutcome'(i[0]);
      cycle(1'b1, npc, np, 1'b0, '0, NOT_TAKEN, 1'b0);
      exp_q.push_back({npc, np});
    end
    n_cmp++;
    if ({bfq.o_push_ready, bfq.o_count} !== {1'b0, 4'd8}) begin
      n_err++;
      $display("FAIL full_status: got ready=%b count=%0d exp 0 8", bfq.o_push_ready, bfq.o_count);
    end
    cycle(1'b1, 32'hdead, TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    n_cmp++;
    if (bfq.o_count !== 4'd8) begin
      n_err++;
      $display("FAIL full_drop: got count=%0d exp 8", bfq.o_count);
    end
    hd = exp_q.pop_front();
    cycle(1'b1, 32'h2000, TAKEN, 1'b1, hd[AW:1], TAKEN, 1'b0);
    got = fb_snap(); exp = {1'b1, 32'h1000, NOT_TAKEN, TAKEN, 1'b1};
    n_cmp++;
    if ({got, bfq.o_count} !== {exp, 4'd7}) begin
      n_err++;
      $display("FAIL full_pop_push: got %h count=%0d exp %h count=7", got, bfq.o_count, exp);
    end
    for (int k = 0; k < 16; k++) begin
      npc = 32'h3000 + 32'(4 * k);
      np  = BranchOutcome'(k[1]);
      ro  = BranchOutcome'(k[0]);
      hd  = exp_q.pop_front();
      exp_q.push_back({npc, np});
      cycle(1'b1, npc, np, 1'b1, hd[AW:1], ro, 1'b0);
      got = fb_snap();
      exp = {1'b1, hd, ro, (hd[0] != ro)};
      n_cmp++;
      if ({got, bfq.o_count} !== {exp, 4'd7}) begin
        n_err++;
        $display("FAIL wrap_pair%0d: got %h count=%0d exp %h count=7", k, got, bfq.o_count, exp);
      end
    end
    for (int k = 0; k < 7; k++) begin
      hd = exp_q.pop_front();
      cycle(1'b0, '0, NOT_TAKEN, 1'b1, hd[AW:1], NOT_TAKEN, 1'b0);
      got = fb_snap();
      exp = {1'b1, hd, NOT_TAKEN, hd[0]};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL drain%0d: got %h exp %h", k, got, exp);
      end
    end
    n_cmp++;
    if (bfq.o_empty !== 1'b1) begin
      n_err++;
      $display("FAIL drain_empty: got %b exp 1", bfq.o_empty);
    end
  endtask

  task automatic test_flush();
    logic [35:0] got, exp;
    cycle(1'b1, 32'h400, TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    cycle(1'b1, 32'h404, NOT_TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    cycle(1'b1, 32'h408, TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h400, NOT_TAKEN, 1'b1);
    got = fb_snap(); exp = {1'b1, 32'h400, TAKEN, NOT_TAKEN, 1'b1};
    n_cmp++;
    if ({got, bfq.o_count, bfq.o_empty} !== {exp, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL flush_fb: got %h count=%0d empty=%b exp %h 0 1",
               got, bfq.o_count, bfq.o_empty, exp);
    end
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h404, TAKEN, 1'b0);
    n_cmp++;
    if ({bfq.o_underflow, bfq.o_fb_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL flush_underflow: got uf=%b fbv=%b exp 1 0", bfq.o_underflow, bfq.o_fb_valid);
    end
    step();
    n_cmp++;
    if (bfq.o_underflow !== 1'b0) begin
      n_err++;
      $display("FAIL underflow_pulse: got %b exp 0", bfq.o_underflow);
    end
    cycle(1'b1, 32'h500, TAKEN, 1'b0, '0, NOT_TAKEN, 1'b1);
    n_cmp++;
    if (bfq.o_count !== 4'd0) begin
      n_err++;
      $display("FAIL flush_push_drop: got count=%0d exp 0", bfq.o_count);
    end
    cycle(1'b1, 32'h600, NOT_TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h600, NOT_TAKEN, 1'b0);
    got = fb_snap(); exp = {1'b1, 32'h600, NOT_TAKEN, NOT_TAKEN, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL flush_reuse: got %h exp %h", got, exp);
    end
  endtask

  task automatic test_push_resolve_empty();
    logic [35:0] got, exp;
    cycle(1'b1, 32'h200, TAKEN, 1'b1, 32'h200, NOT_TAKEN, 1'b0);
    n_cmp++;
    if ({bfq.o_underflow, bfq.o_count, bfq.o_fb_valid} !== {1'b1, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL empty_pr: got uf=%b count=%0d fbv=%b exp 1 1 0",
               bfq.o_underflow, bfq.o_count, bfq.o_fb_valid);
    end
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h200, TAKEN, 1'b0);
    got = fb_snap(); exp = {1'b1, 32'h200, TAKEN, TAKEN, 1'b0};
    n_cmp++;
    if ({got, bfq.o_count} !== {exp, 4'd0}) begin
      n_err++;
      $display("FAIL empty_pr_fb: got %h count=%0d exp %h 0", got, bfq.o_count, exp);
    end
  endtask

  task automatic test_pc_check();
    logic [35:0] got, exp;
    cycle(1'b1, 32'h300, TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h304, NOT_TAKEN, 1'b0);
`ifdef BFQ_PC_CHECK_EN
    n_cmp++;
    if ({bfq.o_pc_mismatch, bfq.o_fb_valid, bfq.o_count} !== {1'b1, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL pc_check: got pcm=%b fbv=%b count=%0d exp 1 0 0",
               bfq.o_pc_mismatch, bfq.o_fb_valid, bfq.o_count);
    end
`else
    got = fb_snap(); exp = {1'b1, 32'h300, TAKEN, NOT_TAKEN, 1'b1};
    n_cmp++;
    if ({got, bfq.o_pc_mismatch, bfq.o_count} !== {exp, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL pc_nocheck: got %h pcm=%b count=%0d exp %h 0 0",
               got, bfq.o_pc_mismatch, bfq.o_count, exp);
    end
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h700 + 32'(4 * i), TAKEN, 1'b0, '0, NOT_TAKEN, 1'b0);
    end
    cycle(1'b0, '0, NOT_TAKEN, 1'b1, 32'h700, TAKEN, 1'b0);
    n_cmp++;
    if ({bfq.o_count, bfq.o_fb_valid} !== {4'd3, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset: got count=%0d fbv=%b exp 3 1", bfq.o_count, bfq.o_fb_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bfq.o_count, bfq.o_empty, bfq.o_push_ready, fb_snap()} !== {4'd0, 1'b1, 1'b1, 36'd0}) begin
      n_err++;
      $display("FAIL async_reset: got count=%0d empty=%b ready=%b fb=%h exp 0 1 1 0",
               bfq.o_count, bfq.o_empty, bfq.o_push_ready, fb_snap());
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bfq.o_count !== 4'd0) begin
      n_err++;
      $display("FAIL post_reset: got count=%0d exp 0", bfq.o_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_flush();
    test_push_resolve_empty();
    test_pc_check();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish exp finish before 200us");
    $fatal(1);
  end

endmodule
